// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// ALU codes, mux selects, and the per-state Moore control word.
package mips_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned FN_W   = 6;
   localparam int unsigned ALU_W  = 3;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned ST_W   = 4;

   typedef enum logic [ST_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ORIEX   = 4'd10,
      S_IMMWB   = 4'd11,
      S_JEX     = 4'd12
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   localparam logic [FN_W-1:0] F_ADD = 6'b100000;
   localparam logic [FN_W-1:0] F_SUB = 6'b100010;
   localparam logic [FN_W-1:0] F_AND = 6'b100100;
   localparam logic [FN_W-1:0] F_OR  = 6'b100101;
   localparam logic [FN_W-1:0] F_SLT = 6'b101010;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

   localparam logic [SEL_W-1:0] PC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PC_JUMP   = 2'b10;

   // Control outputs that depend only on the state (input-dependent strobes excluded)
   typedef struct packed {
      logic              iord;
      logic              alusrca;
      logic              regdst;
      logic              memtoreg;
      logic              extop;
      logic              regwrite;
      logic              memwrite;
      logic [SEL_W-1:0]  alusrcb;
      logic [SEL_W-1:0]  pcsrc;
      logic [ALU_W-1:0]  alucontrol;
   } ctrl_t;

   function automatic ctrl_t state_ctrl(input state_t s, input logic [ALU_W-1:0] rtype_alu);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alusrcb    = SRCB_FOUR;
            c.alucontrol = ALU_ADD;
            c.pcsrc      = PC_ALU;
         end
         S_DECODE: begin
            c.alusrcb    = SRCB_IMMSH;
            c.alucontrol = ALU_ADD;
         end
         S_MEMADR: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_IMM;
            c.alucontrol = ALU_ADD;
         end
         S_MEMRD:  c.iord = 1'b1;
         S_MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         S_MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_B;
            c.alucontrol = rtype_alu;
         end
         S_RTYPEWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         S_BEQEX: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_B;
            c.alucontrol = ALU_SUB;
            c.pcsrc      = PC_ALUOUT;
         end
         S_ADDIEX: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_IMM;
            c.alucontrol = ALU_ADD;
         end
         S_ORIEX: begin
            c.alusrca    = 1'b1;
            c.alusrcb    = SRCB_IMM;
            c.alucontrol = ALU_OR;
            c.extop      = 1'b1;
         end
         S_IMMWB:  c.regwrite = 1'b1;
         S_JEX:    c.pcsrc = PC_JUMP;
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// R-type ALU decoder: maps funct to an alucontrol code and flags unsupported functs.
module mips_mc_aludec
   import mips_pkg::*;
#(
   parameter int unsigned FUNCTW = 6,
   parameter int unsigned ALUCW  = 3
) (
   input  logic [FUNCTW-1:0] funct,
   output logic [ALUCW-1:0]  alucontrol,
   output logic              legal
);

   always_comb begin
      alucontrol = ALUCW'(ALU_ADD);
      legal      = 1'b1;
      case (FN_W'(funct))
         F_ADD:   alucontrol = ALUCW'(ALU_ADD);
         F_SUB:   alucontrol = ALUCW'(ALU_SUB);
         F_AND:   alucontrol = ALUCW'(ALU_AND);
         F_OR:    alucontrol = ALUCW'(ALU_OR);
         F_SLT:   alucontrol = ALUCW'(ALU_SLT);
         default: legal      = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM with variable-latency memory handshake.
// Optional: define MIPS_MC_BNE_EN to decode bne through the branch state.
module mips_mc_controller
   import mips_pkg::*;
#(
   parameter int unsigned OPW    = 6,
   parameter int unsigned FUNCTW = 6,
   parameter int unsigned ALUCW  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OPW-1:0]    op,
   input  logic [FUNCTW-1:0] funct,
   input  logic              zero,
   input  logic              memready,
   output logic              pcen,
   output logic              irwrite,
   output logic              regwrite,
   output logic              memwrite,
   output logic              iord,
   output logic              alusrca,
   output logic              regdst,
   output logic              memtoreg,
   output logic              extop,
   output logic [1:0]        alusrcb,
   output logic [1:0]        pcsrc,
   output logic [ALUCW-1:0]  alucontrol,
   output logic              illegal,
   output logic [3:0]        state
);

   state_t           cur;
   state_t           nxt;
   state_t           target;
   ctrl_t            ctrl;
   logic [ALUCW-1:0] rtype_alu;
   logic             funct_legal;
   logic             take_branch;
`ifdef MIPS_MC_BNE_EN
   logic             is_bne;
`endif

   mips_mc_aludec #(
      .FUNCTW (FUNCTW),
      .ALUCW  (ALUCW)
   ) u_aludec (
      .funct      (funct),
      .alucontrol (rtype_alu),
      .legal      (funct_legal)
   );

   // Decode target; S_FETCH doubles as "unsupported instruction"
   always_comb begin
      target = S_FETCH;
      case (OP_W'(op))
         OP_LW, OP_SW: target = S_MEMADR;
         OP_RTYPE:     target = funct_legal ? S_RTYPEEX : S_FETCH;
         OP_BEQ:       target = S_BEQEX;
`ifdef MIPS_MC_BNE_EN
         OP_BNE:       target = S_BEQEX;
`endif
         OP_ADDI:      target = S_ADDIEX;
         OP_ORI:       target = S_ORIEX;
         OP_J:         target = S_JEX;
         default:      target = S_FETCH;
      endcase
   end

   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH:   nxt = memready ? S_DECODE : S_FETCH;
         S_DECODE:  nxt = target;
         S_MEMADR:  nxt = (OP_W'(op) == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   nxt = memready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   nxt = memready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: nxt = S_RTYPEWB;
         S_ADDIEX,
         S_ORIEX:   nxt = S_IMMWB;
         default:   nxt = S_FETCH;
      endcase
   end

   // State and state-only controls are registered together from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur  <= S_FETCH;
         ctrl <= state_ctrl(S_FETCH, ALU_ADD);
`ifdef MIPS_MC_BNE_EN
         is_bne <= 1'b0;
`endif
      end else begin
         cur  <= nxt;
         ctrl <= state_ctrl(nxt, ALU_W'(rtype_alu));
`ifdef MIPS_MC_BNE_EN
         if (cur == S_DECODE) begin
            is_bne <= (OP_W'(op) == OP_BNE);
         end
`endif
      end
   end

`ifdef MIPS_MC_BNE_EN
   assign take_branch = is_bne ? ~zero : zero;
`else
   assign take_branch = zero;
`endif

   // Input-dependent strobes are forced low while reset is asserted
   assign pcen    = ~reset & (((cur == S_FETCH) & memready) |
                              ((cur == S_BEQEX) & take_branch) |
                              (cur == S_JEX));
   assign irwrite = ~reset & (cur == S_FETCH) & memready;
   assign illegal = ~reset & (cur == S_DECODE) & (target == S_FETCH);

   assign regwrite   = ctrl.regwrite;
   assign memwrite   = ctrl.memwrite;
   assign iord       = ctrl.iord;
   assign alusrca    = ctrl.alusrca;
   assign regdst     = ctrl.regdst;
   assign memtoreg   = ctrl.memtoreg;
   assign extop      = ctrl.extop;
   assign alusrcb    = ctrl.alusrcb;
   assign pcsrc      = ctrl.pcsrc;
   assign alucontrol = ALUCW'(ctrl.alucontrol);
   assign state      = cur;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: random instruction stream against a per-instruction
// reference model; honours MIPS_MC_BNE_EN when defined.
module tb_mips_mc_controller;
   import mips_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, extop, illegal;
      logic [1:0] alusrcb, pcsrc;
      logic [2:0] aluc;
   } obs_t;

   typedef struct packed {
      logic       rst, mr, z;
      logic [5:0] op, fn;
      obs_t       exp;
   } step_t;

   logic       clk = 1'b0;
   logic       reset, zero, memready;
   logic [5:0] op, funct;
   logic       pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, extop, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   step_t prog[$];
   obs_t  sb_q[$];
   int    checks = 0;
   int    failures = 0;

   logic [5:0] g_op, g_fn;
   logic       g_bne, g_ill;
   logic [2:0] g_ralu;

   mips_mc_controller dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
      .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
      .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg), .extop(extop),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
      .state(state)
   );

   always #5 clk = ~clk;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // {legal, alucontrol} for an R-type funct
   function automatic logic [3:0] rdec(input logic [5:0] f);
      case (f)
         6'b100000: return 4'b1_010;
         6'b100010: return 4'b1_110;
         6'b100100: return 4'b1_000;
         6'b100101: return 4'b1_001;
         6'b101010: return 4'b1_111;
         default:   return 4'b0_000;
      endcase
   endfunction

   // Expected outputs of one cycle spent in state s
   function automatic obs_t exp_of(input state_t s, input logic mr, input logic z);
      obs_t o;
      o = '0;
      o.st = s;
      case (s)
         S_FETCH:   begin o.alusrcb = 2'b01; o.aluc = 3'b010; o.irwrite = mr; o.pcen = mr; end
         S_DECODE:  begin o.alusrcb = 2'b11; o.aluc = 3'b010; o.illegal = g_ill; end
         S_MEMADR:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluc = 3'b010; end
         S_MEMRD:   o.iord = 1'b1;
         S_MEMWB:   begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
         S_MEMWR:   begin o.iord = 1'b1; o.memwrite = 1'b1; end
         S_RTYPEEX: begin o.alusrca = 1'b1; o.aluc = g_ralu; end
         S_RTYPEWB: begin o.regdst = 1'b1; o.regwrite = 1'b1; end
         S_BEQEX:   begin o.alusrca = 1'b1; o.aluc = 3'b110; o.pcsrc = 2'b01;
                          o.pcen = g_bne ? ~z : z; end
         S_ADDIEX:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluc = 3'b010; end
         S_ORIEX:   begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluc = 3'b001; o.extop = 1'b1; end
         S_IMMWB:   o.regwrite = 1'b1;
         S_JEX:     begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
         default:   o = '0;
      endcase
      return o;
   endfunction

   task automatic step(input state_t s, input logic mr, input logic z);
      prog.push_back({1'b0, mr, z, g_op, g_fn, exp_of(s, mr, z)});
   endtask

   // Reset cycle: state FETCH, every strobe low regardless of memready
   task automatic rstep();
      prog.push_back({1'b1, rb(), rb(), g_op, g_fn, exp_of(S_FETCH, 1'b0, 1'b0)});
   endtask

   task automatic illegal_decode();
      g_ill = 1'b1;
      step(S_DECODE, rb(), rb());
   endtask

   // One instruction: fw fetch wait cycles, mw memory wait cycles, zb zero flag in branch
   task automatic gen(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                      input logic zb);
      logic [3:0] rd;
      g_op = o; g_fn = f; g_bne = 1'b0; g_ill = 1'b0; g_ralu = 3'b000;
      repeat (fw) step(S_FETCH, 1'b0, rb());
      step(S_FETCH, 1'b1, rb());
      case (o)
         6'b100011: begin
            step(S_DECODE, rb(), rb()); step(S_MEMADR, rb(), rb());
            repeat (mw) step(S_MEMRD, 1'b0, rb());
            step(S_MEMRD, 1'b1, rb()); step(S_MEMWB, rb(), rb());
         end
         6'b101011: begin
            step(S_DECODE, rb(), rb()); step(S_MEMADR, rb(), rb());
            repeat (mw) step(S_MEMWR, 1'b0, rb());
            step(S_MEMWR, 1'b1, rb());
         end
         6'b000000: begin
            rd = rdec(f);
            if (rd[3]) begin
               g_ralu = rd[2:0];
               step(S_DECODE, rb(), rb()); step(S_RTYPEEX, rb(), rb()); step(S_RTYPEWB, rb(), rb());
            end else begin
               illegal_decode();
            end
         end
         6'b000100: begin step(S_DECODE, rb(), rb()); step(S_BEQEX, rb(), zb); end
         6'b000101: begin
`ifdef MIPS_MC_BNE_EN
            g_bne = 1'b1;
            step(S_DECODE, rb(), rb()); step(S_BEQEX, rb(), zb);
`else
            illegal_decode();
`endif
         end
         6'b001000: begin step(S_DECODE, rb(), rb()); step(S_ADDIEX, rb(), rb()); step(S_IMMWB, rb(), rb()); end
         6'b001101: begin step(S_DECODE, rb(), rb()); step(S_ORIEX, rb(), rb()); step(S_IMMWB, rb(), rb()); end
         6'b000010: begin step(S_DECODE, rb(), rb()); step(S_JEX, rb(), rb()); end
         default:   illegal_decode();
      endcase
   endtask

   // Store interrupted by reset while waiting on memory
   task automatic sw_abort();
      g_op = 6'b101011; g_fn = 6'($urandom); g_bne = 1'b0; g_ill = 1'b0; g_ralu = 3'b000;
      step(S_FETCH, 1'b1, rb()); step(S_DECODE, rb(), rb()); step(S_MEMADR, rb(), rb());
      step(S_MEMWR, 1'b0, rb()); step(S_MEMWR, 1'b0, rb());
      rstep(); rstep();
   endtask

   // Monitor: every cycle the driver has posted an expectation for is compared here
   obs_t act;
   assign act = {state, pcen, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg,
                 extop, illegal, alusrcb, pcsrc, alucontrol};

   always @(negedge clk) begin
      obs_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL ctrl t=%0t got st=%0d vec=%h exp st=%0d vec=%h",
                     $time, act.st, act, e.st, e);
         end
      end
   end

   initial begin
      step_t s;
      logic [5:0] legal_fn [5];
      logic [5:0] ops [8];
      int k;
      legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      ops      = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
                   6'b001101, 6'b000010};
      reset = 1'b1; zero = 1'b0; memready = 1'b0; op = '0; funct = '0;
      g_op = '0; g_fn = '0; g_bne = 1'b0; g_ill = 1'b0; g_ralu = '0;

      rstep(); rstep();
      gen(6'b100011, 6'b000000, 0, 3, 1'b0);          // lw, three memory wait cycles
      gen(6'b101011, 6'b000000, 1, 2, 1'b0);          // sw, two memory wait cycles
      gen(6'b000100, 6'b000000, 0, 0, 1'b1);          // beq taken
      gen(6'b000100, 6'b000000, 0, 0, 1'b0);          // beq not taken
      gen(6'b000101, 6'b000000, 0, 0, 1'b0);          // bne, zero clear
      gen(6'b000000, 6'b101010, 0, 0, 1'b0);          // slt
      gen(6'b000000, 6'b000111, 0, 0, 1'b0);          // unsupported funct
      gen(6'b001101, 6'b000000, 2, 0, 1'b0);          // ori
      gen(6'b001000, 6'b000000, 0, 0, 1'b0);          // addi
      gen(6'b000010, 6'b000000, 0, 0, 1'b0);          // j
      gen(6'b111111, 6'b000000, 0, 0, 1'b0);          // unsupported opcode
      sw_abort();
      gen(6'b100011, 6'b000000, 0, 0, 1'b0);          // lw, memready tied high
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 9);
         if (k < 8)
            gen(ops[k], (k == 2 && rb()) ? 6'($urandom) : legal_fn[$urandom_range(0, 4)],
                $urandom_range(0, 2), $urandom_range(0, 3), rb());
         else if (k == 8)
            gen(6'($urandom), 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), rb());
         else
            sw_abort();
      end

      // Driver: apply one cycle's inputs just after each rising edge
      while (prog.size() > 0) begin
         s = prog.pop_front();
         @(posedge clk);
         #1;
         reset = s.rst; memready = s.mr; zero = s.z; op = s.op; funct = s.fn;
         sb_q.push_back(s.exp);
      end
      @(posedge clk);
      @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain left=%0d required=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have parameters: OPW, 6, opcode field width; FUNCTW, 6, funct field width; ALUCW, 3, alucontrol width.
REQ-002 SHALL have ports, one per line below; clock and reset first.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high.
- op  input  OPW  instr[31:26].
- funct  input  FUNCTW  instr[5:0].
- zero  input  1  ALU zero flag.
- memready  input  1  memory done strobe (variable-latency memory).
- pcen, irwrite, regwrite, memwrite  output  1 each  write strobes.
- iord, alusrca, regdst, memtoreg, extop  output  1 each  mux selects (extop=1: zero-extend immediate).
- alusrcb  output  2  00 B, 01 const 4, 10 imm, 11 imm<<2.
- pcsrc  output  2  00 ALU result, 01 aluout register, 10 jump target.
- alucontrol  output  ALUCW  010 add, 110 sub, 000 and, 001 or, 111 slt.
- illegal  output  1  one-cycle pulse on unsupported op/funct.
- state  output  4  current FSM state, debug.

Function
REQ-003 SHALL be a multicycle Moore FSM; outputs default 0 in every state unless listed.
REQ-004 FETCH: iord=0, alusrcb=01, add, pcsrc=00; irwrite=pcen=memready; stay until memready=1, then DECODE.
REQ-005 DECODE: alusrcb=11, add; next by op: 100011/101011 MEMADR, 000000 RTYPEEX (if funct legal), 000100 BEQEX, 001000 ADDIEX, 001101 ORIEX, 000010 JEX.
REQ-006 MEMADR: alusrca=1, alusrcb=10, add; next MEMRD (lw) or MEMWR (sw).
REQ-007 MEMRD: iord=1; wait for memready, then MEMWB.
REQ-008 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-009 MEMWR: iord=1, memwrite=1 held until cycle memready=1 inclusive; then FETCH.
REQ-010 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); next RTYPEWB.
REQ-011 RTYPEWB: regdst=1, regwrite=1; next FETCH.
REQ-012 BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero; next FETCH.
REQ-013 ADDIEX: alusrca=1, alusrcb=10, add; ORIEX: same with extop=1, or; both next IMMWB.
REQ-014 IMMWB: regdst=0, regwrite=1; next FETCH.
REQ-015 JEX: pcsrc=10, pcen=1; next FETCH.
REQ-016 Unsupported op, or op=000000 with unsupported funct, in DECODE: illegal=1 that cycle, next FETCH, no strobe asserted.
REQ-017 Latencies with memready tied 1: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3 cycles.
REQ-018 memready in non-waiting states SHALL be ignored.

Reset
REQ-019 reset=1 SHALL force state=FETCH asynchronously and hold pcen, irwrite, regwrite, memwrite, illegal at 0 while asserted.
REQ-020 Reset mid-instruction (incl. MEMWR wait) SHALL abort it; no strobe after reset assertion; first fetch on first edge after deassertion.

Configuration
REQ-021 Macro MIPS_MC_BNE_EN defined: op 000101 in DECODE goes to BEQEX with pcen=~zero; undefined: op 000101 is illegal per REQ-016.

Structure
REQ-022 Package mips_pkg SHALL hold the state enum, opcode and funct localparams, alucontrol codes, alusrcb/pcsrc encodings.
REQ-023 SHALL instantiate one combinational sub-module mips_mc_aludec (funct -> alucontrol, legal flag).

Verification
REQ-024 lw, memready low 3 cycles in MEMRD -> states FETCH,DECODE,MEMADR,MEMRD x4,MEMWB; regwrite=1,memtoreg=1 once.
REQ-025 sw, memready low 2 cycles -> memwrite=1 for exactly 3 cycles, iord=1, then FETCH.
REQ-026 beq zero=1 -> pcen=1,pcsrc=01 in BEQEX; zero=0 -> pcen=0; op 000101 zero=0 -> pcen=1 only with MIPS_MC_BNE_EN.
REQ-027 R-type funct 101010 -> alucontrol=111 in RTYPEEX, regdst=1 regwrite=1 next; funct 000111 -> illegal pulse, back to FETCH.
REQ-028 ori -> extop=1, alucontrol=001 in ORIEX, regwrite=1 regdst=0 in IMMWB.
REQ-029 reset asserted in MEMWR wait -> memwrite drops same cycle, state=FETCH, no regwrite.
